// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module : mips_mem_pkg
// Brief  : Shared FSM/owner encodings and default widths for mem_port_arbiter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Single-port memory arbiter between instruction fetch and data side
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int              SC_W       = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);
    localparam logic [1:0]      LAT_LOAD   = 2'(MEM_LAT - 1);

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [1:0]      lat_q, lat_d;
    logic [SC_W-1:0] starve_q, starve_d;
    logic            we_q, we_d;
    logic            fetch_wins;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            lat_q    <= 2'd0;
            starve_q <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            lat_q    <= lat_d;
            starve_q <= starve_d;
            we_q     <= we_d;
        end
    end

    assign fetch_wins = if_req && (!d_req || (starve_q == STARVE_TOP));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        we_d      = we_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;

        if (state_q == ST_WAIT) begin
            busy = 1'b1;
            if (lat_q == 2'd0) begin
                state_d = ST_IDLE;
                if (owner_q == OWN_IF) begin
                    if_valid = 1'b1;
                    if_rdata = mem_rdata;
                end else begin
                    d_valid = 1'b1;
                    // Writes complete with a valid pulse but carry no read data.
                    d_rdata = we_q ? '0 : mem_rdata;
                end
            end else begin
                lat_d = lat_q - 2'd1;
            end
        end else if (!reset) begin
            if (fetch_wins) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
                state_d  = ST_WAIT;
                owner_d  = OWN_IF;
                we_d     = 1'b0;
                lat_d    = LAT_LOAD;
                starve_d = '0;
            end else if (d_req) begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                state_d   = ST_WAIT;
                owner_d   = OWN_D;
                we_d      = d_we;
                lat_d     = LAT_LOAD;
                if (if_req && (starve_q != STARVE_TOP)) begin
                    starve_d = starve_q + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Self-checking bench; instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic                  clk;
    logic [1:0]            reset, if_req, d_req, d_we;
    logic [1:0][31:0]      if_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]            if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
    logic [1:0][31:0]      if_rdata, d_rdata, mem_addr, mem_wdata;

    int checks   = 0;
    int failures = 0;

    // Transaction-level reference model state, indexed by instance.
    int m_now[2], m_gnt_at[2], m_resp_at[2], m_losses[2];
    bit m_own_d[2], m_we[2];
    bit prev_gi[2], prev_gd[2];
    logic          e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_mem_en, e_mem_we, e_busy;
    logic [31:0]   e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
    logic [134:0]  e_vec, a_vec;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_valid(d_valid[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_valid(d_valid[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [134:0] act_vec(input int k);
        return {if_gnt[k], d_gnt[k], if_valid[k], d_valid[k], mem_en[k], mem_we[k], busy[k],
                if_rdata[k], d_rdata[k], mem_addr[k], mem_wdata[k]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int k);
        m_now[k] = 0; m_gnt_at[k] = -10; m_resp_at[k] = -10; m_losses[k] = 0;
        m_own_d[k] = 1'b0; m_we[k] = 1'b0; prev_gi[k] = 1'b0; prev_gd[k] = 1'b0;
    endtask

    // Expected outputs for the current cycle from timestamps of the last grant.
    task automatic model_eval(input int k);
        bit bz, vl, fw;
        bz = (m_now[k] > m_gnt_at[k]) && (m_now[k] <= m_resp_at[k]);
        vl = (m_now[k] == m_resp_at[k]);
        e_if_gnt = 0; e_d_gnt = 0; e_mem_en = 0; e_mem_we = 0;
        e_mem_addr = 0; e_mem_wdata = 0;
        if (!bz && !reset[k]) begin
            fw = if_req[k] && (!d_req[k] || m_losses[k] == SMAX);
            e_if_gnt = fw;
            e_d_gnt  = d_req[k] && !fw;
            if (e_if_gnt) begin
                e_mem_en = 1; e_mem_addr = if_addr[k];
            end else if (e_d_gnt) begin
                e_mem_en = 1; e_mem_we = d_we[k]; e_mem_addr = d_addr[k]; e_mem_wdata = d_wdata[k];
            end
        end
        e_busy     = bz;
        e_if_valid = vl && !m_own_d[k];
        e_d_valid  = vl && m_own_d[k];
        e_if_rdata = e_if_valid ? mem_rdata[k] : 32'h0;
        e_d_rdata  = (e_d_valid && !m_we[k]) ? mem_rdata[k] : 32'h0;
        e_vec = {e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_mem_en, e_mem_we, e_busy,
                 e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata};
    endtask

    task automatic model_commit(input int k);
        if (e_if_gnt || e_d_gnt) begin
            m_gnt_at[k]  = m_now[k];
            m_resp_at[k] = m_now[k] + lat_of(k);
            m_own_d[k]   = e_d_gnt;
            m_we[k]      = e_d_gnt && d_we[k];
        end
        if (e_if_gnt) m_losses[k] = 0;
        else if (e_d_gnt && if_req[k] && m_losses[k] < SMAX) m_losses[k]++;
        prev_gi[k] = e_if_gnt;
        prev_gd[k] = e_d_gnt;
        m_now[k]++;
    endtask

    task automatic test_reset();
        reset = 2'b11;
        if_req = '0; d_req = '0; d_we = '0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== '0) begin
                failures++;
                $display("FAIL reset_outputs[%0d] actual=%h required=0", k, act_vec(k));
            end
        end
        reset = 2'b00;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_vec(k) !== '0) begin
                failures++;
                $display("FAIL idle_after_reset[%0d] actual=%h required=0", k, act_vec(k));
            end
        end
        next_cycle();
    endtask

    task automatic test_single_fetch();
        if_req[0] = 1; if_addr[0] = 32'h0040_0000; mem_rdata[0] = 32'hCAFE_0001;
        @(negedge clk);
        checks++;
        if ({if_gnt[0], d_gnt[0], mem_en[0], mem_we[0], busy[0], mem_addr[0]} !== {5'b10100, 32'h0040_0000}) begin
            failures++;
            $display("FAIL fetch_grant actual=%b/%h required=10100/00400000",
                     {if_gnt[0], d_gnt[0], mem_en[0], mem_we[0], busy[0]}, mem_addr[0]);
        end
        next_cycle();
        if_req[0] = 0;
        @(negedge clk);
        checks++;
        if ({if_valid[0], busy[0], if_gnt[0], mem_en[0], if_rdata[0]} !== {4'b1100, 32'hCAFE_0001}) begin
            failures++;
            $display("FAIL fetch_valid actual=%b/%h required=1100/cafe0001",
                     {if_valid[0], busy[0], if_gnt[0], mem_en[0]}, if_rdata[0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({if_valid[0], busy[0], if_rdata[0]} !== 34'h0) begin
            failures++;
            $display("FAIL fetch_done actual=%b/%h required=00/0", {if_valid[0], busy[0]}, if_rdata[0]);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        if_req[0] = 1; if_addr[0] = 32'h0040_0040;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h1001_0000; mem_rdata[0] = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if ({d_gnt[0], if_gnt[0], mem_addr[0]} !== {2'b10, 32'h1001_0000}) begin
            failures++;
            $display("FAIL prio_data_first actual=%b/%h required=10/10010000", {d_gnt[0], if_gnt[0]}, mem_addr[0]);
        end
        next_cycle();
        d_req[0] = 0;
        @(negedge clk);
        checks++;
        if ({d_valid[0], if_gnt[0], d_gnt[0], d_rdata[0]} !== {3'b100, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL prio_data_valid actual=%b/%h required=100/0badf00d",
                     {d_valid[0], if_gnt[0], d_gnt[0]}, d_rdata[0]);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({if_gnt[0], mem_addr[0]} !== {1'b1, 32'h0040_0040}) begin
            failures++;
            $display("FAIL prio_fetch_next actual=%b/%h required=1/00400040", if_gnt[0], mem_addr[0]);
        end
        next_cycle();
        if_req[0] = 0;
        next_cycle();
    endtask

    task automatic test_starve();
        string seq;
        int    cyc;
        seq = "";
        cyc = 0;
        if_req[0] = 1; if_addr[0] = 32'h0040_0100;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h1001_0100;
        while (seq.len() < 6 && cyc < 40) begin
            @(negedge clk);
            if (d_gnt[0]) seq = {seq, "D"};
            else if (if_gnt[0]) seq = {seq, "I"};
            next_cycle();
            cyc++;
        end
        checks++;
        if (seq != "DDDDID") begin
            failures++;
            $display("FAIL starve_sequence actual=%s required=DDDDID", seq);
        end
        if_req[0] = 0; d_req[0] = 0;
        repeat (2) next_cycle();
    endtask

    task automatic test_write_lat3();
        d_req[1] = 1; d_we[1] = 1; d_addr[1] = 32'h1001_0020; d_wdata[1] = 32'hDEAD_BEEF;
        mem_rdata[1] = 32'h55AA_55AA;
        @(negedge clk);
        checks++;
        if ({d_gnt[1], mem_en[1], mem_we[1], mem_wdata[1]} !== {3'b111, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL write_grant actual=%b/%h required=111/deadbeef",
                     {d_gnt[1], mem_en[1], mem_we[1]}, mem_wdata[1]);
        end
        next_cycle();
        d_req[1] = 0; d_we[1] = 0; if_req[1] = 1; if_addr[1] = 32'h0040_0200;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if ({if_gnt[1], d_gnt[1], mem_en[1], busy[1], d_valid[1], d_rdata[1]} !==
                {4'b0001, (i == 3), 32'h0}) begin
                failures++;
                $display("FAIL write_wait_T+%0d actual=%b/%h required=0001%0d/0", i,
                         {if_gnt[1], d_gnt[1], mem_en[1], busy[1], d_valid[1]}, d_rdata[1], (i == 3));
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (if_gnt[1] !== 1'b1) begin
            failures++;
            $display("FAIL write_then_fetch actual=%b required=1", if_gnt[1]);
        end
        next_cycle();
        if_req[1] = 0;
        repeat (4) next_cycle();
    endtask

    task automatic test_reset_in_wait();
        if_req[1] = 1; if_addr[1] = 32'h0040_0300; mem_rdata[1] = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (if_gnt[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_grant actual=%b required=1", if_gnt[1]);
        end
        next_cycle();
        if_req[1] = 0;
        reset[1]  = 1;
        #1;
        checks++;
        if (act_vec(1) !== '0) begin
            failures++;
            $display("FAIL rst_wait_outputs actual=%h required=0", act_vec(1));
        end
        next_cycle();
        reset[1]  = 0;
        if_req[1] = 1; if_addr[1] = 32'h0040_0400;
        @(negedge clk);
        checks++;
        if ({if_gnt[1], mem_addr[1]} !== {1'b1, 32'h0040_0400}) begin
            failures++;
            $display("FAIL rst_release_grant actual=%b/%h required=1/00400400", if_gnt[1], mem_addr[1]);
        end
        next_cycle();
        if_req[1] = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (if_valid[1] !== (i == 3)) begin
                failures++;
                $display("FAIL rst_no_stale_valid_%0d actual=%b required=%0d", i, if_valid[1], (i == 3));
            end
            next_cycle();
        end
    endtask

    task automatic test_random(input int k, input int n);
        reset[k] = 1;
        if_req[k] = 0; d_req[k] = 0;
        next_cycle();
        reset[k] = 0;
        model_reset(k);
        for (int c = 0; c < n; c++) begin
            if (if_req[k] && !prev_gi[k]) begin
                if ($urandom_range(7) == 0) if_req[k] = 0;
            end else begin
                if_req[k]  = 1'($urandom_range(1));
                if_addr[k] = $urandom;
            end
            if (d_req[k] && !prev_gd[k]) begin
                if ($urandom_range(7) == 0) d_req[k] = 0;
            end else begin
                d_req[k]   = ($urandom_range(3) != 0);
                d_we[k]    = 1'($urandom_range(1));
                d_addr[k]  = $urandom;
                d_wdata[k] = $urandom;
            end
            mem_rdata[k] = $urandom;
            @(negedge clk);
            model_eval(k);
            a_vec = act_vec(k);
            checks++;
            if (a_vec !== e_vec) begin
                failures++;
                $display("FAIL random[%0d] cycle %0d actual=%h required=%h", k, c, a_vec, e_vec);
            end
            model_commit(k);
            next_cycle();
        end
        if_req[k] = 0; d_req[k] = 0; d_we[k] = 0;
        repeat (4) next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_starve();
        test_write_lat3();
        test_reset_in_wait();
        test_random(0, 300);
        test_random(1, 300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
